// File: rtl/magcompare_seq.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands CHUNK bits per cycle
// from the MSB chunk and stops on the first differing chunk.
module magcompare_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             LT,
  output logic             EQ
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_q, done_q, gt_q, lt_q, eq_q;

  logic [WIDTH-1:0] a_sh_c, b_sh_c;
  logic [CHUNK-1:0] a_ch_c, b_ch_c;
  logic             last_c;

  // Shift the current chunk to the top so chunk 0 is always the MSB chunk.
  assign a_sh_c = a_q << (CHUNK * 32'(idx_q));
  assign b_sh_c = b_q << (CHUNK * 32'(idx_q));
  assign a_ch_c = a_sh_c[WIDTH-1 -: CHUNK];
  assign b_ch_c = b_sh_c[WIDTH-1 -: CHUNK];
  assign last_c = (idx_q == IDXW'(NCHUNK - 1));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            a_q     <= A ^ {signed_mode, {(WIDTH-1){1'b0}}};
            b_q     <= B ^ {signed_mode, {(WIDTH-1){1'b0}}};
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (a_ch_c != b_ch_c) begin
            gt_q    <= (a_ch_c > b_ch_c);
            lt_q    <= (a_ch_c < b_ch_c);
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (last_c) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign GT   = gt_q;
  assign LT   = lt_q;
  assign EQ   = eq_q;

endmodule
